eth_tx_arb: RTL and testbench
=============================

// Module: eth_tx_arb
// PURPOSE
//  Arbitrates the single GMII transmit path between the ARP and UDP engines in the gmii_tx_clk domain.
//  Sits between the engines' gmii_tx_en/txd outputs and the gmii_to_rgmii TX input.
//  Grants whole frames via req/gnt, muxes the granted source onto the GMII bus, then enforces the inter-frame gap (IFG).
//  Uses round-robin when both engines request, and reclaims grants that are never used.
// PARAMETERS
//  IFG_CYCLES    12    idle cycles forced after each frame (gmii_tx_en low)
//  START_TMO     1024  cycles a grant may sit unused before revocation (>=2)
// PORTS
//  clk             in   1   gmii_tx_clk; single clock
//  rst             in   1   asynchronous, active-high reset
//  arp_req         in   1   ARP wants to send one frame; level, held until frame start
//  arp_gnt         out  1   ARP may start its frame; level
//  arp_gmii_tx_en  in   1   ARP GMII data valid
//  arp_gmii_txd    in   8   ARP GMII data
//  udp_req         in   1   UDP wants to send one frame
//  udp_gnt         out  1   UDP may start its frame
//  udp_gmii_tx_en  in   1   UDP GMII data valid
//  udp_gmii_txd    in   8   UDP GMII data
//  gmii_tx_en      out  1   merged GMII data valid (to RGMII converter)
//  gmii_txd        out  8   merged GMII data
//  busy            out  1   high in GRANT, BUSY and IFG states
//  err_tmo         out  1   1-cycle pulse when an unused grant is revoked
//  err_intrude     out  1   1-cycle pulse when a non-granted source drives tx_en high
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; last_src=UDP, so ARP wins the first tie; counters 0.
//  Reset mid-frame drops gmii_tx_en immediately (async). The truncated frame is not resumed.
//  FSM:
//   IDLE : if any req: pick src (one req -> that one; both -> opposite of last_src); gnt[src]=1 next cycle; -> GRANT.
//   GRANT: gnt[src] held high; tmo counter counts up.
//          src tx_en=1 -> BUSY, gnt drops the same cycle BUSY is entered, last_src<=src.
//          tmo reaches START_TMO-1 with no tx_en -> gnt drops, err_tmo pulse, last_src<=src, -> IDLE.
//   BUSY : output follows src; src tx_en falling (1->0) -> IFG, ifg counter cleared.
//   IFG  : counter counts IFG_CYCLES cycles -> IDLE. Requests arriving here wait; none are lost.
//  Datapath:
//   gmii_tx_en/gmii_txd are registered copies of the granted source's tx_en/txd.
//   Latency is exactly 1 cycle; every byte passes, including the byte on the GRANT->BUSY cycle.
//   Outside GRANT/BUSY, gmii_tx_en=0 and gmii_txd=8'h00.
//  Ports driven by the non-granted source are ignored.
//   Its tx_en=1 pulses err_intrude on each rising edge and never reaches the output.
//  Minimum spacing: frame end (registered gmii_tx_en falls) to next gnt >= IFG_CYCLES+1 cycles.
//  A req dropped while in GRANT does not revoke the grant; only tx_en or the timeout ends GRANT.
//  Both reqs constant high: grants alternate ARP, UDP, ARP, ...
//  Counters saturate at their terminal values and never wrap.
// TESTING
//  1 arp_req alone; ARP sends a 60-byte frame one cycle after gnt
//    -> gmii_tx_en high 60 cycles, delayed 1 cycle from input
//    -> gmii_txd matches input byte-for-byte
//    -> busy low exactly 13 cycles after frame end.
//  2 arp_req and udp_req both raised in the same cycle after reset
//    -> ARP granted first; UDP granted IFG_CYCLES+1 cycles after ARP frame end
//    -> no overlap of gmii_tx_en between the two frames.
//  3 udp gnt given, UDP never asserts tx_en
//    -> gnt drops after 1024 cycles; err_tmo pulses once
//    -> a pending arp_req is granted the next cycle.
//  4 while ARP is BUSY, udp_gmii_tx_en pulses high for 5 cycles with txd=8'hAA
//    -> err_intrude pulses once; output stays pure ARP data.
//  5 rst asserted mid-frame, 20 bytes into a UDP frame
//    -> gmii_tx_en=0 and both gnts=0 immediately
//    -> after release, the first grant goes to ARP on a tie.
//  6 both reqs held for 6 frames
//    -> grant order ARP,UDP,ARP,UDP,ARP,UDP; every gap >= 12 idle cycles.

Source files
------------

// File: rtl/eth_tx_arb_if.sv
// Bundles the ARP/UDP request-grant handshakes, their GMII sources and the merged GMII output.
// master = engines/consumer side, slave = the arbiter.
interface eth_tx_arb_if;
    logic       arp_req;
    logic       arp_gnt;
    logic       arp_gmii_tx_en;
    logic [7:0] arp_gmii_txd;
    logic       udp_req;
    logic       udp_gnt;
    logic       udp_gmii_tx_en;
    logic [7:0] udp_gmii_txd;
    logic       gmii_tx_en;
    logic [7:0] gmii_txd;

    modport master (
        output arp_req, arp_gmii_tx_en, arp_gmii_txd,
        output udp_req, udp_gmii_tx_en, udp_gmii_txd,
        input  arp_gnt, udp_gnt, gmii_tx_en, gmii_txd
    );

    modport slave (
        input  arp_req, arp_gmii_tx_en, arp_gmii_txd,
        input  udp_req, udp_gmii_tx_en, udp_gmii_txd,
        output arp_gnt, udp_gnt, gmii_tx_en, gmii_txd
    );
endinterface

// File: rtl/eth_tx_arb.sv
// Whole-frame round-robin arbiter for the shared GMII TX path (ARP vs UDP), with forced
// inter-frame gap, unused-grant revocation and intrusion detection.
module eth_tx_arb #(
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned START_TMO  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    eth_tx_arb_if.slave bus,
    output logic        busy_o,
    output logic        err_tmo_o,
    output logic        err_intrude_o
);

    localparam int unsigned TmoW = $clog2(START_TMO);
    localparam int unsigned IfgW = $clog2(IFG_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(START_TMO - 1);
    localparam logic [IfgW-1:0] IfgLast = IfgW'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StGrant, StBusy, StIfg} state_e;

    state_e          state_q, state_d;
    logic            src_q, src_d;    // 0 = ARP, 1 = UDP
    logic            last_q, last_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [IfgW-1:0] ifg_q, ifg_d;
    logic            tx_en_q, tx_en_d;
    logic [7:0]      txd_q, txd_d;
    logic            arp_en_q, udp_en_q;
    logic            err_tmo_q, err_tmo_d;
    logic            err_intr_q, err_intr_d;

    logic            owned;
    logic            src_en;
    logic [7:0]      src_txd;

    assign owned   = (state_q == StGrant) || (state_q == StBusy);
    assign src_en  = src_q ? bus.udp_gmii_tx_en : bus.arp_gmii_tx_en;
    assign src_txd = src_q ? bus.udp_gmii_txd : bus.arp_gmii_txd;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        last_d    = last_q;
        tmo_d     = tmo_q;
        ifg_d     = ifg_q;
        err_tmo_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.arp_req || bus.udp_req) begin
                    state_d = StGrant;
                    tmo_d   = '0;
                    src_d   = (bus.arp_req && bus.udp_req) ? ~last_q : bus.udp_req;
                end
            end
            StGrant: begin
                if (src_en) begin
                    state_d = StBusy;
                    last_d  = src_q;
                end else if (tmo_q == TmoLast) begin
                    state_d   = StIdle;
                    err_tmo_d = 1'b1;
                    last_d    = src_q;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StBusy: begin
                // Entered on tx_en high, so a low tx_en here is the falling edge.
                if (!src_en) begin
                    state_d = StIfg;
                    ifg_d   = '0;
                end
            end
            StIfg: begin
                if (ifg_q == IfgLast) begin
                    state_d = StIdle;
                end else begin
                    ifg_d = ifg_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_en_d    = owned & src_en;
        txd_d      = owned ? src_txd : 8'h00;
        err_intr_d = (bus.arp_gmii_tx_en && !arp_en_q && !(owned && !src_q)) ||
                     (bus.udp_gmii_tx_en && !udp_en_q && !(owned && src_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            src_q      <= 1'b0;
            last_q     <= 1'b1;
            tmo_q      <= '0;
            ifg_q      <= '0;
            tx_en_q    <= 1'b0;
            txd_q      <= 8'h00;
            arp_en_q   <= 1'b0;
            udp_en_q   <= 1'b0;
            err_tmo_q  <= 1'b0;
            err_intr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            last_q     <= last_d;
            tmo_q      <= tmo_d;
            ifg_q      <= ifg_d;
            tx_en_q    <= tx_en_d;
            txd_q      <= txd_d;
            arp_en_q   <= bus.arp_gmii_tx_en;
            udp_en_q   <= bus.udp_gmii_tx_en;
            err_tmo_q  <= err_tmo_d;
            err_intr_q <= err_intr_d;
        end
    end

    assign bus.arp_gnt    = (state_q == StGrant) && !src_q;
    assign bus.udp_gnt    = (state_q == StGrant) && src_q;
    assign bus.gmii_tx_en = tx_en_q;
    assign bus.gmii_txd   = txd_q;
    assign busy_o         = (state_q != StIdle);
    assign err_tmo_o      = err_tmo_q;
    assign err_intrude_o  = err_intr_q;

endmodule

// File: tb/tb_eth_tx_arb.sv
// Scoreboard bench for eth_tx_arb: engines push expected bytes/frames/grant order into queues,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_eth_tx_arb;

    localparam int IFG = 12;
    localparam int TMO = 1024;

    typedef struct {
        int len;
        int start;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, err_tmo, err_intrude;
    int   cyc = 0;

    eth_tx_arb_if bus ();

    eth_tx_arb #(
        .IFG_CYCLES(IFG),
        .START_TMO (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy_o       (busy),
        .err_tmo_o    (err_tmo),
        .err_intrude_o(err_intrude)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    logic [7:0] bq[$];
    frame_t     fq[$];
    bit         eq[$];

    // Monitor-maintained observations
    int tmo_pulses = 0, intr_pulses = 0;
    int last_high = 0, last_fall = 0, busy_fall = 0, gap_at_gnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_ge(input string name, input int act, input int lo);
        total++;
        if (act >= lo) passed++;
        else $display("FAIL %s: got %0d, required >= %0d", name, act, lo);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s: got no DUT event, expected one within bound", name);
    endtask

    task automatic drive(input bit src, input bit en, input logic [7:0] d);
        if (src) begin
            bus.udp_gmii_tx_en = en;
            bus.udp_gmii_txd   = d;
        end else begin
            bus.arp_gmii_tx_en = en;
            bus.arp_gmii_txd   = d;
        end
    endtask

    task automatic set_req(input bit src, input bit v);
        if (src) bus.udp_req = v;
        else bus.arp_req = v;
    endtask

    function automatic bit gnt_of(input bit src);
        return src ? bus.udp_gnt : bus.arp_gnt;
    endfunction

    task automatic send_frame(input bit src, input int len, input int dly);
        int w = 0;
        logic [7:0] b;
        set_req(src, 1'b1);
        do begin
            @(posedge clk); #1; w++;
        end while (!gnt_of(src) && w < 5000);
        if (!gnt_of(src)) begin
            fail_now(src ? "udp_gnt_wait" : "arp_gnt_wait");
            set_req(src, 1'b0);
            return;
        end
        repeat (dly) begin @(posedge clk); #1; end
        fq.push_back('{len: len, start: cyc + 1});
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            drive(src, 1'b1, b);
            bq.push_back(b);
            if (i == 0) set_req(src, 1'b0);
            @(posedge clk); #1;
        end
        drive(src, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.arp_req = 1'b0;
        bus.udp_req = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        bq.delete();
        fq.delete();
        eq.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", int'({bus.arp_gnt, bus.udp_gnt, bus.gmii_tx_en, bus.gmii_txd,
                                  busy, err_tmo, err_intrude}), 0);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Monitor / scoreboard
    initial begin
        bit in_frame = 0, have_last = 0, arp_p = 0, udp_p = 0, busy_p = 0;
        int cur_len = 0, exp_len = 0;
        frame_t f;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 0; have_last = 0; arp_p = 0; udp_p = 0; busy_p = 0;
            end else begin
                if (bus.gmii_tx_en) begin
                    if (!in_frame) begin
                        in_frame = 1;
                        cur_len  = 0;
                        if (have_last) chk_ge("ifg_idle_cycles", cyc - last_fall, IFG);
                        if (fq.size() == 0) fail_now("frame_expected");
                        else begin
                            f = fq.pop_front();
                            chk("latency_start", cyc, f.start);
                            exp_len = f.len;
                        end
                    end
                    cur_len++;
                    if (bq.size() == 0) fail_now("byte_expected");
                    else chk("txd", int'(bus.gmii_txd), int'(bq.pop_front()));
                    last_high = cyc;
                end else begin
                    chk("txd_idle", int'(bus.gmii_txd), 0);
                    if (in_frame) begin
                        in_frame  = 0;
                        have_last = 1;
                        last_fall = cyc;
                        chk("frame_len", cur_len, exp_len);
                    end
                end
                if ((bus.arp_gnt && !arp_p) || (bus.udp_gnt && !udp_p)) begin
                    chk("gnt_onehot", int'(bus.arp_gnt & bus.udp_gnt), 0);
                    if (eq.size() == 0) fail_now("gnt_expected");
                    else chk("gnt_order", int'(bus.udp_gnt), int'(eq.pop_front()));
                    if (have_last) begin
                        gap_at_gnt = cyc - last_fall;
                        chk_ge("gnt_spacing", gap_at_gnt, IFG + 1);
                    end
                end
                if (busy_p && !busy) busy_fall = cyc;
                if (err_tmo) tmo_pulses++;
                if (err_intrude) intr_pulses++;
                arp_p  = bus.arp_gnt;
                udp_p  = bus.udp_gnt;
                busy_p = busy;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, cnt, drop_cyc, intr0, tmo0;
        do_reset();

        // 1: lone ARP frame, 60 bytes
        eq.push_back(1'b0);
        send_frame(1'b0, 60, 0);
        repeat (20) @(negedge clk);
        chk("t1_busy_low_after_frame", busy_fall - last_high, IFG + 1);

        // 2: simultaneous requests after reset
        do_reset();
        eq.push_back(1'b0);
        eq.push_back(1'b1);
        fork
            send_frame(1'b0, int'($urandom_range(46, 80)), 0);
            send_frame(1'b1, int'($urandom_range(46, 80)), int'($urandom_range(0, 3)));
        join
        repeat (4) @(negedge clk);
        chk("t2_udp_gnt_gap", gap_at_gnt, IFG + 1);

        // 3: UDP grant never used, ARP pending
        do_reset();
        eq.push_back(1'b1);
        eq.push_back(1'b0);
        tmo0 = tmo_pulses;
        bus.udp_req = 1'b1;
        w = 0;
        @(negedge clk);
        while (!bus.udp_gnt && w < 100) begin @(negedge clk); w++; end
        cnt = 0;
        while (bus.udp_gnt && cnt < 2000) begin
            cnt++;
            if (cnt == 100) bus.arp_req = 1'b1;
            @(negedge clk);
        end
        bus.udp_req = 1'b0;
        drop_cyc = cyc;
        chk("t3_gnt_high_cycles", cnt, TMO);
        w = 0;
        while (!bus.arp_gnt && w < 10) begin @(negedge clk); w++; end
        chk("t3_arp_gnt_delay", cyc - drop_cyc, 1);
        chk("t3_err_tmo_pulses", tmo_pulses - tmo0, 1);
        send_frame(1'b0, int'($urandom_range(46, 80)), 0);

        // 4: UDP intrudes while ARP is busy
        do_reset();
        eq.push_back(1'b0);
        intr0 = intr_pulses;
        fork
            send_frame(1'b0, 50, int'($urandom_range(0, 2)));
            begin
                w = 0;
                while (!bus.gmii_tx_en && w < 200) begin @(posedge clk); #1; w++; end
                repeat (5) begin @(posedge clk); #1; end
                drive(1'b1, 1'b1, 8'hAA);
                repeat (5) begin @(posedge clk); #1; end
                drive(1'b1, 1'b0, 8'h00);
            end
        join
        repeat (4) @(negedge clk);
        chk("t4_err_intrude_pulses", intr_pulses - intr0, 1);

        // 5: reset 20 bytes into a UDP frame
        do_reset();
        eq.push_back(1'b1);
        bus.udp_req = 1'b1;
        w = 0;
        while (!bus.udp_gnt && w < 200) begin @(posedge clk); #1; w++; end
        fq.push_back('{len: 0, start: cyc + 1});
        for (int i = 0; i < 21; i++) begin
            drive(1'b1, 1'b1, 8'(i + 1));
            bq.push_back(8'(i + 1));
            if (i == 0) bus.udp_req = 1'b0;
            if (i < 20) begin @(posedge clk); #1; end
        end
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_drop", int'({bus.gmii_tx_en, bus.arp_gnt, bus.udp_gnt, busy}), 0);
        do_reset();
        eq.push_back(1'b0);
        eq.push_back(1'b1);
        fork
            send_frame(1'b1, int'($urandom_range(46, 80)), 0);
            send_frame(1'b0, int'($urandom_range(46, 80)), 0);
        join

        // 6: both engines always requesting, six frames
        do_reset();
        for (int i = 0; i < 3; i++) begin
            eq.push_back(1'b0);
            eq.push_back(1'b1);
        end
        fork
            for (int i = 0; i < 3; i++)
                send_frame(1'b0, int'($urandom_range(46, 90)), int'($urandom_range(0, 3)));
            for (int j = 0; j < 3; j++)
                send_frame(1'b1, int'($urandom_range(46, 90)), int'($urandom_range(0, 3)));
        join

        repeat (30) @(negedge clk);
        chk("total_err_tmo", tmo_pulses, 1);
        chk("total_err_intrude", intr_pulses, 1);
        chk("bytes_left", bq.size(), 0);
        chk("frames_left", fq.size(), 0);
        chk("grants_left", eq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
